// File: rtl/filter_pkg.sv
// Shared types and derivation helpers for the image-filter line-buffer controller.
// The kernel geometry (HALF, LINE_NUM, select width) is derived from KSIZE only.
package filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_FLUSH
  } state_e;

  localparam int BORDER_ZERO = 0;
  localparam int BORDER_REPL = 1;

  function automatic int calc_half(input int ksize);
    return ksize / 2;
  endfunction

  function automatic int calc_line_num(input int ksize);
    return ksize + 1;
  endfunction

  function automatic int calc_sel_w(input int ksize);
    return $clog2(ksize + 1);
  endfunction

endpackage

// File: rtl/filter_line_timing.sv
// Per-output-line timing generator: sync/DE regeneration, read addressing and
// per-kernel-column validity, all relative to the triggering input line sync.
module filter_line_timing
  import filter_pkg::*;
#(
  parameter int H_ACT     = 1920,
  parameter int HBP       = 3,
  parameter int HSY       = 1,
  parameter int PIXEL_DLY = 2,
  parameter int KSIZE     = 5,
  parameter int ADDR_W    = 11
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic              first_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              hs_o,
  output logic              vs_o,
  output logic              ren_o,
  output logic [ADDR_W-1:0] raddr_o,
  output logic              de_o,
  output logic [KSIZE-1:0]  col_vld_o
);

  localparam int HALF = calc_half(KSIZE);
  localparam int RS   = PIXEL_DLY + HBP - 1;
  localparam int LAST = RS + H_ACT;
  localparam int TW   = $clog2(LAST + 1) + 1;

  logic              active_q;
  logic [TW-1:0]     tcnt_q;
  logic              first_q;
  logic              de_q;
  logic [ADDR_W-1:0] x_q;
  logic              ren;
  logic [ADDR_W-1:0] raddr;
  int                t;

  assign t = int'(tcnt_q);

  // tcnt_q holds the cycle offset from the triggering sync while a line is active
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_q <= 1'b0;
      tcnt_q   <= '0;
      first_q  <= 1'b0;
      de_q     <= 1'b0;
      x_q      <= '0;
    end else if (abort_i) begin
      active_q <= 1'b0;
      tcnt_q   <= '0;
      de_q     <= 1'b0;
      x_q      <= '0;
    end else begin
      if (start_i) begin
        active_q <= 1'b1;
        tcnt_q   <= TW'(1);
        first_q  <= first_i;
      end else if (active_q) begin
        if (t == LAST) begin
          active_q <= 1'b0;
          tcnt_q   <= '0;
        end else begin
          tcnt_q <= tcnt_q + 1'b1;
        end
      end
      de_q <= ren;
      x_q  <= raddr;
    end
  end

  always_comb begin
    ren   = active_q && (t >= RS) && (t <= RS + H_ACT - 1);
    raddr = ren ? ADDR_W'(t - RS) : '0;
  end

  always_comb begin
    int xc;
    xc = 0;
    for (int c = 0; c < KSIZE; c++) begin
      xc = int'(x_q) - HALF + c;
      col_vld_o[c] = de_q && (xc >= 0) && (xc <= H_ACT - 1);
    end
  end

  assign busy_o  = active_q;
  assign hs_o    = active_q && (t >= PIXEL_DLY) && (t <= PIXEL_DLY + HSY - 1);
  assign vs_o    = hs_o && first_q && (t == PIXEL_DLY);
  assign ren_o   = ren;
  assign raddr_o = raddr;
  assign de_o    = de_q;

endmodule

// File: rtl/filter_line_ctrl.sv
// Line-buffer controller: writes input lines into a ring of LINE_NUM memories and
// maps each output line's kernel rows onto those memories.
module filter_line_ctrl
  import filter_pkg::*;
#(
  parameter int H_ACT       = 1920,
  parameter int V_ACT       = 1080,
  parameter int HBP         = 3,
  parameter int HSY         = 1,
  parameter int PIXEL_DLY   = 2,
  parameter int KSIZE       = 5,
  parameter int ADDR_W      = 11,
  parameter int BORDER_MODE = BORDER_ZERO
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 i_vs,
  input  logic                                 i_hs,
  input  logic                                 i_de,
  output logic                                 o_mem_wen,
  output logic [calc_line_num(KSIZE)-1:0]      o_mem_wsel,
  output logic [ADDR_W-1:0]                    o_mem_waddr,
  output logic                                 o_mem_ren,
  output logic [ADDR_W-1:0]                    o_mem_raddr,
  output logic [KSIZE*calc_sel_w(KSIZE)-1:0]   o_row_sel,
  output logic [KSIZE-1:0]                     o_row_vld,
  output logic [KSIZE-1:0]                     o_col_vld,
  output logic                                 o_vs,
  output logic                                 o_hs,
  output logic                                 o_de,
  output logic                                 o_frame_err
);

  localparam int HALF     = calc_half(KSIZE);
  localparam int LINE_NUM = calc_line_num(KSIZE);
  localparam int SEL_W    = calc_sel_w(KSIZE);
  localparam int LW       = $clog2(V_ACT + KSIZE + 2) + 1;
  localparam int CW       = ADDR_W + 1;

  logic                    wen_q;
  logic [LINE_NUM-1:0]     wsel_q;
  logic [ADDR_W-1:0]       waddr_q;
  logic [CW-1:0]           pixCnt_q;
  logic [SEL_W-1:0]        wptr_q;
  logic [LW-1:0]           inLine_q;
  logic                    deFall;
  logic                    runErr;

  state_e                  state_q, state_d;
  logic [LW-1:0]           outLine_q, outLine_d;
  logic [KSIZE*SEL_W-1:0]  rowSel_q, rowSel_d;
  logic [KSIZE-1:0]        rowVld_q, rowVld_d;
  logic                    err_q;
  logic                    start, abort, vsErr, overrun, trigOk, ahead, busy;

  assign deFall = wen_q && !i_de;
  assign runErr = deFall && (pixCnt_q != CW'(H_ACT)) && (state_q != ST_IDLE);

  // A short or long line is flagged but still advances the ring like any other line
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wen_q    <= 1'b0;
      wsel_q   <= '0;
      waddr_q  <= '0;
      pixCnt_q <= '0;
      wptr_q   <= '0;
      inLine_q <= '0;
    end else begin
      wen_q  <= i_de;
      wsel_q <= i_de ? (LINE_NUM'(1) << wptr_q) : '0;
      if (i_de) begin
        waddr_q <= ADDR_W'(pixCnt_q);
        if (pixCnt_q != '1) pixCnt_q <= pixCnt_q + 1'b1;
      end else begin
        pixCnt_q <= '0;
      end
      if (i_vs) begin
        wptr_q   <= '0;
        inLine_q <= '0;
      end else if (deFall) begin
        wptr_q   <= (wptr_q == SEL_W'(LINE_NUM - 1)) ? '0 : wptr_q + 1'b1;
        inLine_q <= inLine_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      outLine_q <= '0;
      rowSel_q  <= '0;
      rowVld_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      outLine_q <= outLine_d;
      err_q     <= vsErr | overrun | runErr;
      if (start) begin
        rowSel_q <= rowSel_d;
        rowVld_q <= rowVld_d;
      end
    end
  end

  assign ahead = (int'(inLine_q) > int'(outLine_q) + HALF) && (int'(outLine_q) < V_ACT);

  // i_vs takes priority over everything, including a coincident i_hs
  always_comb begin
    state_d   = state_q;
    outLine_d = outLine_q;
    start     = 1'b0;
    abort     = 1'b0;
    vsErr     = 1'b0;
    overrun   = 1'b0;
    trigOk    = 1'b0;
    if (i_vs) begin
      state_d   = ST_FILL;
      outLine_d = '0;
      if (state_q != ST_IDLE) begin
        vsErr = 1'b1;
        abort = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: trigOk = 1'b0;
        ST_FILL: begin
          trigOk = ahead;
          if (int'(inLine_q) >= HALF + 1) state_d = ST_RUN;
        end
        ST_RUN: begin
          trigOk = ahead;
          if (int'(inLine_q) == V_ACT) state_d = ST_FLUSH;
        end
        ST_FLUSH: begin
          trigOk = int'(outLine_q) < V_ACT;
          if ((int'(outLine_q) == V_ACT) && !busy) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (i_hs && trigOk) begin
        if (busy) begin
          overrun = 1'b1;
        end else begin
          start     = 1'b1;
          outLine_d = outLine_q + 1'b1;
        end
      end
    end
  end

  // Negative sources wrap modulo LINE_NUM; their rows are flagged invalid anyway
  always_comb begin
    int src;
    src      = 0;
    rowSel_d = '0;
    rowVld_d = '0;
    for (int r = 0; r < KSIZE; r++) begin
      src         = int'(outLine_q) - HALF + r;
      rowVld_d[r] = (src >= 0) && (src <= V_ACT - 1);
      if (BORDER_MODE == BORDER_REPL) begin
        if (src < 0) src = 0;
        else if (src > V_ACT - 1) src = V_ACT - 1;
      end
      rowSel_d[r*SEL_W +: SEL_W] = SEL_W'(((src % LINE_NUM) + LINE_NUM) % LINE_NUM);
    end
  end

  filter_line_timing #(
    .H_ACT    (H_ACT),
    .HBP      (HBP),
    .HSY      (HSY),
    .PIXEL_DLY(PIXEL_DLY),
    .KSIZE    (KSIZE),
    .ADDR_W   (ADDR_W)
  ) u_timing (
    .clk      (clk),
    .rstn     (rstn),
    .start_i  (start),
    .first_i  (outLine_q == '0),
    .abort_i  (abort),
    .busy_o   (busy),
    .hs_o     (o_hs),
    .vs_o     (o_vs),
    .ren_o    (o_mem_ren),
    .raddr_o  (o_mem_raddr),
    .de_o     (o_de),
    .col_vld_o(o_col_vld)
  );

  assign o_mem_wen   = wen_q;
  assign o_mem_wsel  = wsel_q;
  assign o_mem_waddr = waddr_q;
  assign o_row_sel   = rowSel_q;
  assign o_row_vld   = rowVld_q;
  assign o_frame_err = err_q;

endmodule

// File: tb/tb_filter_line_ctrl.sv
// Directed scoreboard bench for filter_line_ctrl at KSIZE=3, 8x4 frames, with a
// zero-pad and a replicate instance sharing the same input stream.
module tb_filter_line_ctrl;
  import filter_pkg::*;

  localparam int H_ACT     = 8;
  localparam int V_ACT     = 4;
  localparam int KSIZE     = 3;
  localparam int ADDR_W    = 4;
  localparam int HBP       = 3;
  localparam int HSY       = 1;
  localparam int PIXEL_DLY = 2;
  localparam int LN        = 4;
  localparam int SW        = 2;
  localparam int LP        = 20;
  localparam int DE_START  = 4;

  typedef struct {
    int line;
    int hsCycle;
  } expLine_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic i_vs = 1'b0, i_hs = 1'b0, i_de = 1'b0;

  logic              o_mem_wen0, o_mem_ren0, o_vs0, o_hs0, o_de0, o_frame_err0;
  logic [LN-1:0]     o_mem_wsel0;
  logic [ADDR_W-1:0] o_mem_waddr0, o_mem_raddr0;
  logic [KSIZE*SW-1:0] o_row_sel0;
  logic [KSIZE-1:0]  o_row_vld0, o_col_vld0;

  logic              o_mem_wen1, o_mem_ren1, o_vs1, o_hs1, o_de1, o_frame_err1;
  logic [LN-1:0]     o_mem_wsel1;
  logic [ADDR_W-1:0] o_mem_waddr1, o_mem_raddr1;
  logic [KSIZE*SW-1:0] o_row_sel1;
  logic [KSIZE-1:0]  o_row_vld1, o_col_vld1;

  int checks = 0;
  int errors = 0;
  int cycCount = 0;

  expLine_t lineQ[$];
  int       wselQ[$];
  int       expOut, inModel;

  expLine_t cur;
  bit  hsPrev, wenPrev, errPrev, deOpen, abortSeen;
  int  deCount, renCount, wcnt, curWsel, linesDone, vsCount, errCount;

  always #5 clk = ~clk;
  always @(posedge clk) cycCount++;

  filter_line_ctrl #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .HBP(HBP), .HSY(HSY), .PIXEL_DLY(PIXEL_DLY),
    .KSIZE(KSIZE), .ADDR_W(ADDR_W), .BORDER_MODE(0)
  ) u_dut0 (
    .clk(clk), .rstn(rstn), .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de),
    .o_mem_wen(o_mem_wen0), .o_mem_wsel(o_mem_wsel0), .o_mem_waddr(o_mem_waddr0),
    .o_mem_ren(o_mem_ren0), .o_mem_raddr(o_mem_raddr0), .o_row_sel(o_row_sel0),
    .o_row_vld(o_row_vld0), .o_col_vld(o_col_vld0), .o_vs(o_vs0), .o_hs(o_hs0),
    .o_de(o_de0), .o_frame_err(o_frame_err0)
  );

  filter_line_ctrl #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .HBP(HBP), .HSY(HSY), .PIXEL_DLY(PIXEL_DLY),
    .KSIZE(KSIZE), .ADDR_W(ADDR_W), .BORDER_MODE(1)
  ) u_dut1 (
    .clk(clk), .rstn(rstn), .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de),
    .o_mem_wen(o_mem_wen1), .o_mem_wsel(o_mem_wsel1), .o_mem_waddr(o_mem_waddr1),
    .o_mem_ren(o_mem_ren1), .o_mem_raddr(o_mem_raddr1), .o_row_sel(o_row_sel1),
    .o_row_vld(o_row_vld1), .o_col_vld(o_col_vld1), .o_vs(o_vs1), .o_hs(o_hs1),
    .o_de(o_de1), .o_frame_err(o_frame_err1)
  );

  // Reference row/column mapping straight from the kernel-window definition
  function automatic logic [KSIZE*SW-1:0] expSel(input int o, input int mode);
    logic [KSIZE*SW-1:0] res;
    int src, s;
    res = '0;
    for (int r = 0; r < KSIZE; r++) begin
      src = o - KSIZE / 2 + r;
      if (mode == 1) begin
        if (src < 0) src = 0;
        if (src > V_ACT - 1) src = V_ACT - 1;
      end
      s = ((src % LN) + LN) % LN;
      res[r*SW +: SW] = s[SW-1:0];
    end
    return res;
  endfunction

  function automatic logic [KSIZE-1:0] expVld(input int o);
    logic [KSIZE-1:0] res;
    int src;
    for (int r = 0; r < KSIZE; r++) begin
      src = o - KSIZE / 2 + r;
      res[r] = (src >= 0) && (src <= V_ACT - 1);
    end
    return res;
  endfunction

  function automatic logic [KSIZE*SW-1:0] selMask(input int o);
    logic [KSIZE*SW-1:0] res;
    logic [KSIZE-1:0] v;
    v = expVld(o);
    res = '0;
    for (int r = 0; r < KSIZE; r++) res[r*SW +: SW] = {SW{v[r]}};
    return res;
  endfunction

  function automatic logic [KSIZE-1:0] expCol(input int x);
    logic [KSIZE-1:0] res;
    int xc;
    for (int c = 0; c < KSIZE; c++) begin
      xc = x - KSIZE / 2 + c;
      res[c] = (xc >= 0) && (xc <= H_ACT - 1);
    end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input bit vs, input bit hs, input bit de);
    @(negedge clk);
    i_vs = vs;
    i_hs = hs;
    i_de = de;
  endtask

  // One input line slot: optional sync-triggered output line and deLen pixels
  task automatic applyStimulus(input int deLen, input bit trig);
    for (int k = 0; k < LP; k++) begin
      drive(1'b0, k == 0, (k >= DE_START) && (k < DE_START + deLen));
      if (k == 0) begin
        if (trig) begin
          lineQ.push_back('{expOut, cycCount});
          expOut++;
        end
        if (deLen > 0) begin
          wselQ.push_back(1 << (inModel % LN));
          inModel++;
        end
      end
    end
  endtask

  task automatic startFrame();
    drive(1'b1, 1'b0, 1'b0);
    inModel = 0;
    expOut  = 0;
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic runFrame(input int shortLen);
    applyStimulus(H_ACT, 1'b0);
    applyStimulus(shortLen, 1'b0);
    applyStimulus(H_ACT, 1'b1);
    applyStimulus(H_ACT, 1'b1);
    applyStimulus(0, 1'b1);
    applyStimulus(0, 1'b1);
    applyStimulus(0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (o_hs0 && !hsPrev) begin
        checkOutput("line_expected", lineQ.size() > 0, 1);
        if (lineQ.size() > 0) begin
          cur = lineQ.pop_front();
          checkOutput("hs_delay", cycCount - cur.hsCycle, PIXEL_DLY);
          checkOutput("vs_with_hs", o_vs0, cur.line == 0);
          checkOutput("row_vld", o_row_vld0, expVld(cur.line));
          checkOutput("row_sel_zero", o_row_sel0 & selMask(cur.line),
                      expSel(cur.line, 0) & selMask(cur.line));
          checkOutput("row_sel_repl", o_row_sel1, expSel(cur.line, 1));
        end
        deCount  = 0;
        renCount = 0;
        deOpen   = 1'b1;
      end else if (o_vs0) begin
        checkOutput("vs_outside_line_start", o_vs0, 0);
      end
      if (o_vs0) vsCount++;
      if (o_mem_ren0) begin
        checkOutput("raddr", o_mem_raddr0, renCount);
        renCount++;
      end
      if (o_de0) begin
        if (deCount == 0) checkOutput("de_delay", cycCount - cur.hsCycle, PIXEL_DLY + HBP);
        checkOutput("col_vld", o_col_vld0, expCol(deCount));
        deCount++;
      end else if (deOpen && deCount > 0) begin
        if (abortSeen) begin
          abortSeen = 1'b0;
        end else begin
          checkOutput("de_count", deCount, H_ACT);
          linesDone++;
        end
        deOpen = 1'b0;
      end
      if (o_mem_wen0) begin
        if (!wenPrev) begin
          checkOutput("write_expected", wselQ.size() > 0, 1);
          if (wselQ.size() > 0) curWsel = wselQ.pop_front();
          wcnt = 0;
        end
        checkOutput("wsel", o_mem_wsel0, curWsel);
        checkOutput("waddr", o_mem_waddr0, wcnt);
        wcnt++;
      end
      if (o_frame_err0) begin
        errCount++;
        checkOutput("err_one_cycle", errPrev, 0);
      end
      hsPrev  = o_hs0;
      wenPrev = o_mem_wen0;
      errPrev = o_frame_err0;
    end
  end

  initial begin
    abortSeen = 1'b0;
    linesDone = 0;
    vsCount   = 0;
    errCount  = 0;
    expOut    = 0;
    inModel   = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {o_mem_wen0, o_mem_wsel0, o_mem_waddr0, o_mem_ren0, o_mem_raddr0, o_row_sel0,
                 o_row_vld0, o_col_vld0, o_vs0, o_hs0, o_de0, o_frame_err0}, 0);
    checkOutput("reset_state", u_dut0.state_q, ST_IDLE);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("idle_outputs", {o_hs0, o_de0, o_mem_ren0, o_mem_wen0, o_frame_err0}, 0);

    $display("[TB] frame 1: normal");
    startFrame();
    checkOutput("fill_after_vs", u_dut0.state_q, ST_FILL);
    runFrame(H_ACT);
    checkOutput("frame1_lines", linesDone, 4);
    checkOutput("frame1_vs", vsCount, 1);
    checkOutput("frame1_err", errCount, 0);
    checkOutput("frame1_queue", lineQ.size(), 0);
    checkOutput("frame1_idle", u_dut0.state_q, ST_IDLE);

    $display("[TB] frame 2: vs injected after input line 2");
    startFrame();
    applyStimulus(H_ACT, 1'b0);
    applyStimulus(H_ACT, 1'b0);
    applyStimulus(H_ACT, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    lineQ.push_back('{expOut, cycCount});
    expOut++;
    repeat (6) drive(1'b0, 1'b0, 1'b0);
    checkOutput("de_before_abort", o_de0, 1);
    abortSeen = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    inModel = 0;
    expOut  = 0;
    drive(1'b0, 1'b0, 1'b0);
    checkOutput("abort_err", o_frame_err0, 1);
    checkOutput("abort_de", o_de0, 0);
    checkOutput("abort_ren", o_mem_ren0, 0);
    checkOutput("abort_hs", o_hs0, 0);
    checkOutput("abort_fill", u_dut0.state_q, ST_FILL);
    runFrame(H_ACT);
    checkOutput("frame2_lines", linesDone, 9);
    checkOutput("frame2_vs", vsCount, 3);
    checkOutput("frame2_err", errCount, 1);
    checkOutput("frame2_queue", lineQ.size(), 0);

    $display("[TB] frame 3: short input line");
    startFrame();
    runFrame(6);
    checkOutput("frame3_lines", linesDone, 13);
    checkOutput("frame3_vs", vsCount, 4);
    checkOutput("frame3_err", errCount, 2);
    checkOutput("frame3_queue", lineQ.size(), 0);
    checkOutput("frame3_wqueue", wselQ.size(), 0);
    checkOutput("frame3_idle", u_dut0.state_q, ST_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
